alu_seq_param: RTL and testbench
================================

Name: alu_seq_param

Overview:
Parametrised-width, handshaked successor to the 32-bit ALU. It executes the same eight operations (AND, OR, XOR, NOR, signed less-than, ADD, SUB, unsigned MOD) on WIDTH-bit operands. All results are registered, and the block adds status flags. MOD runs as an iterative restoring unit; while it runs, the block stalls new requests through in_ready. The block sits between the register-read stage and write-back, and the issuing controller sequences it with in_valid/in_ready.

Parameters:
WIDTH, 32, operand/result width; legal range 2..64.
CNT_W, $clog2(WIDTH+1), MOD iteration counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  request present
in_ready  output  1  block can accept a request this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
alu_op  input  3  opcode, sampled on accept
out_valid  output  1  one-cycle pulse, result/flags valid
result  output  WIDTH  registered result
flag_zero  output  1  result == 0
flag_carry  output  1  carry-out (ADD) / no-borrow (SUB); 0 otherwise
flag_ovf  output  1  signed overflow (ADD/SUB); 0 otherwise
flag_dz  output  1  MOD with b == 0

Behaviour:
- Reset: rst is sampled on the rising clk edge. When asserted, state goes to IDLE; in_ready=1 after reset; out_valid, result, and all flags are 0.
- Opcode map (unchanged from the existing ALU): 000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLT (signed, result is 1 or 0 zero-extended), 101 ADD, 110 SUB (a-b), 111 MOD (a mod b, unsigned).
- Accept: a request is accepted on a rising edge when in_valid && in_ready. a, b, and alu_op are captured on that edge. When in_ready=0, inputs are ignored.
- FSM states: IDLE, MOD_RUN.
  - IDLE: in_ready=1.
  - Accept of a non-MOD op: result and flags register on the accepting edge, and out_valid=1 for the following cycle. State stays IDLE, so back-to-back single-cycle ops give a result every cycle.
  - Accept of MOD with b != 0: load the remainder to 0, the quotient shift register to a, and the counter to WIDTH. Go to MOD_RUN.
  - Accept of MOD with b == 0: short-circuit with latency 1. result=a, flag_dz=1, flag_zero=(a==0). State stays IDLE.
  - MOD_RUN: in_ready=0. Each edge performs one restoring step: shift the remainder left, bring in the next MSB of a, subtract b when rem >= b, and decrement the counter. The edge on which the counter reaches 0 writes result=remainder and sets out_valid for the next cycle. The FSM returns to IDLE on that same edge.
- MOD latency: out_valid is asserted in the cycle after WIDTH edges following the accept edge, i.e. WIDTH+1 cycles from request to visible result. in_ready is low for WIDTH cycles.
- No output backpressure: out_valid is a single-cycle pulse. result and flags hold their last value until the next out_valid.
- Flags are updated only with out_valid.
  - flag_carry and flag_ovf are 0 for non-ADD/SUB ops.
  - flag_dz is 0 for every op except MOD with b == 0.
  - SUB carry = 1 when a >= b unsigned.
  - ovf = sign(a) == sign(b') && sign(res) != sign(a), where b' = b for ADD and ~b+1 for SUB.
- Arithmetic: all results are truncated modulo 2^WIDTH. SLT compares as two's complement and is correct on overflow (uses a<b signed, not the sign of the difference).
- rst during MOD_RUN aborts the operation. The FSM goes to IDLE, no out_valid is emitted, and outputs are cleared.
- in_valid during MOD_RUN is not accepted; the requester must hold it.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_AND..OP_MOD (3-bit);
  - state enum IDLE/MOD_RUN;
  - the flag bundle ordering {dz, ovf, carry, zero}.
- Sub-module mod_iter_unit contains the restoring remainder datapath and counter. Its interface is start, a, b, busy, done pulse, and rem, parametrised by WIDTH. The top holds the FSM, the combinational op datapath, and the output registers.

Test Plan:
- WIDTH=32. Reset, then ADD a=0x7FFFFFFF b=1 -> one cycle later out_valid=1, result=0x80000000, ovf=1, carry=0, zero=0.
- SUB a=5 b=5, then SLT a=0xFFFFFFFF b=1 back-to-back on consecutive cycles -> result 0 (zero=1, carry=1), then result 1. in_ready stays 1 throughout.
- MOD a=100 b=7 -> in_ready low 32 cycles, out_valid exactly 33 cycles after accept, result=2, dz=0. An in_valid held during the run is accepted the first cycle in_ready returns to 1.
- MOD a=0x1234 b=0 -> latency 1, result=0x1234, flag_dz=1.
- MOD a=0xFFFFFFFF b=3 with rst asserted on cycle 10 of the run -> no out_valid, outputs 0, in_ready=1 next cycle. A following AND 0xF0F0F0F0 & 0xFF00FF00 gives 0xF000F000.
- WIDTH=8. ADD 0xFF+0x01 -> result 0x00, carry=1, zero=1. MOD 200 mod 13 -> 5 after 9 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag-bundle layout for the sequential ALU.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND = 3'b000;
  localparam op_t OP_OR  = 3'b001;
  localparam op_t OP_XOR = 3'b010;
  localparam op_t OP_NOR = 3'b011;
  localparam op_t OP_SLT = 3'b100;
  localparam op_t OP_ADD = 3'b101;
  localparam op_t OP_SUB = 3'b110;
  localparam op_t OP_MOD = 3'b111;

  typedef enum logic {
    IDLE    = 1'b0,
    MOD_RUN = 1'b1
  } state_t;

  // Flag bundle, MSB first: {dz, ovf, carry, zero}.
  typedef struct packed {
    logic dz;
    logic ovf;
    logic carry;
    logic zero;
  } flags_t;

  localparam flags_t FLAGS_CLR = '0;

  // Carry and overflow are only meaningful for the adder ops.
  function automatic logic is_arith(input op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_param_if.sv
// Request/result bundle between the issuing controller and the sequential ALU.
// Latency: none, wires only.
// Backpressure: in_ready from the ALU; no backpressure on the result side.
interface alu_seq_param_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_t              alu_op;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             flag_zero;
  logic             flag_carry;
  logic             flag_ovf;
  logic             flag_dz;

  // Issuing controller side.
  modport master (
    output in_valid, a, b, alu_op,
    input  in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf, flag_dz
  );

  // ALU side.
  modport slave (
    input  in_valid, a, b, alu_op,
    output in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf, flag_dz
  );

endinterface

// File: rtl/mod_iter_unit.sv
// Restoring remainder unit: one quotient bit per clock, WIDTH steps per operation.
// Latency: done is raised combinationally during the WIDTH-th step after start, with rem valid alongside.
// Backpressure: none; start is only honoured by the caller while busy is low.
module mod_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rem
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;

  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_step;

  // One restoring step: shift in the next dividend MSB, subtract the divisor if it fits.
  // The remainder before the shift is < divisor, so the shifted value needs one extra bit
  // for the compare, while the subtraction result always fits back into WIDTH bits.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    ge       = (shifted >= {1'b0, div_q});
    rem_step = ge ? (shifted[WIDTH-1:0] - div_q) : shifted[WIDTH-1:0];
  end

  assign busy = (cnt_q != '0);
  assign done = busy && (cnt_q == CNT_W'(1));
  // Exposes the remainder being written on this edge so the final step's value can be
  // captured by the caller on the same edge the counter reaches zero.
  assign rem  = rem_step;

  // Load on start, otherwise iterate while the counter is non-zero.
  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    div_d = div_q;
    if (start) begin
      cnt_d = CNT_W'(WIDTH);
      rem_d = '0;
      quo_d = a;
      div_d = b;
    end else if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
      rem_d = rem_step;
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // State registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/alu_seq_param.sv
// Parametrised-width ALU with registered result/flags; MOD runs iteratively.
// Latency: 1 cycle for logic/compare/add/sub and MOD by zero; WIDTH+1 cycles for MOD.
// Backpressure: in_ready low while MOD iterates; out_valid is a one-cycle pulse, no output stall.
module alu_seq_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_param_if.slave bus
);

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;

  logic             accept;
  logic             mod_start;
  logic             mod_busy;
  logic             mod_done;
  logic [WIDTH-1:0] mod_rem;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic [WIDTH-1:0] b_eff;
  logic             slt;
  logic [WIDTH-1:0] op_res;
  flags_t           op_flags;

  mod_iter_unit #(
    .WIDTH (WIDTH)
  ) u_mod (
    .clk   (clk),
    .rst   (rst),
    .start (mod_start),
    .a     (bus.a),
    .b     (bus.b),
    .busy  (mod_busy),
    .done  (mod_done),
    .rem   (mod_rem)
  );

  assign bus.in_ready = (state_q == IDLE) && !mod_busy;
  assign accept       = bus.in_valid && bus.in_ready;

  // Single-cycle datapath and its flags, evaluated on the request operands.
  always_comb begin
    sum_ext = {1'b0, bus.a} + {1'b0, bus.b};
    // a + ~b + 1: the extra bit is the no-borrow indication (a >= b unsigned).
    dif_ext = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    // Overflow uses the effective addend, i.e. the negated b for SUB.
    b_eff   = (bus.alu_op == OP_SUB) ? (~bus.b + WIDTH'(1)) : bus.b;
    // True signed compare, so the answer stays correct when a-b would overflow.
    slt     = ($signed(bus.a) < $signed(bus.b));

    op_res = '0;
    case (bus.alu_op)
      OP_AND:  op_res = bus.a & bus.b;
      OP_OR:   op_res = bus.a | bus.b;
      OP_XOR:  op_res = bus.a ^ bus.b;
      OP_NOR:  op_res = ~(bus.a | bus.b);
      OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, slt};
      OP_ADD:  op_res = sum_ext[WIDTH-1:0];
      OP_SUB:  op_res = dif_ext[WIDTH-1:0];
      default: op_res = '0;
    endcase

    op_flags      = FLAGS_CLR;
    op_flags.zero = (op_res == '0);
    if (is_arith(bus.alu_op)) begin
      op_flags.carry = (bus.alu_op == OP_ADD) ? sum_ext[WIDTH] : dif_ext[WIDTH];
      op_flags.ovf   = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                       (op_res[WIDTH-1] != bus.a[WIDTH-1]);
    end
  end

  // Next-state and output-register selection for the IDLE / MOD_RUN sequencer.
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    flags_d     = flags_q;
    mod_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.alu_op != OP_MOD) begin
            result_d    = op_res;
            flags_d     = op_flags;
            out_valid_d = 1'b1;
          end else if (bus.b == '0) begin
            // Divide by zero answers immediately with the dividend.
            result_d      = bus.a;
            flags_d       = FLAGS_CLR;
            flags_d.dz    = 1'b1;
            flags_d.zero  = (bus.a == '0);
            out_valid_d   = 1'b1;
          end else begin
            mod_start = 1'b1;
            state_d   = MOD_RUN;
          end
        end
      end
      MOD_RUN: begin
        if (mod_done) begin
          result_d     = mod_rem;
          flags_d      = FLAGS_CLR;
          flags_d.zero = (mod_rem == '0);
          out_valid_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered outputs; reset also aborts a running MOD silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= FLAGS_CLR;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.flag_zero  = flags_q.zero;
  assign bus.flag_carry = flags_q.carry;
  assign bus.flag_ovf   = flags_q.ovf;
  assign bus.flag_dz    = flags_q.dz;

endmodule

// File: tb/tb_alu_seq_param.sv
// Bench for alu_seq_param at WIDTH=32 and WIDTH=8: directed table, hand-built sequences, random.
// Latency: expectations derived from the operation rules, not from the DUT.
// Backpressure: requests are held until in_ready, every wait is bounded.
module tb_alu_seq_param;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_param_if #(.WIDTH(32)) bus32 ();
  alu_seq_param_if #(.WIDTH(8))  bus8 ();

  alu_seq_param #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  alu_seq_param #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    op_t         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;   // {dz, ovf, carry, zero}
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference behaviour from the operation rules, using plain arithmetic.
  function automatic void model(input int w, input op_t op, input logic [63:0] ai,
                                input logic [63:0] bi, output logic [63:0] res,
                                output logic [3:0] fl);
    logic [63:0] mask, msb, a, b, full, bp;
    longint sa, sb;
    logic dz, ovf, cy;
    mask = (64'd1 << w) - 64'd1;
    msb  = 64'd1 << (w - 1);
    a = ai & mask;
    b = bi & mask;
    dz = 1'b0; ovf = 1'b0; cy = 1'b0; bp = 64'd0;
    sa = ((a & msb) != 0) ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb = ((b & msb) != 0) ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b) & mask;
      OP_SLT: res = (sa < sb) ? 64'd1 : 64'd0;
      OP_ADD: begin
        full = a + b;
        res  = full & mask;
        cy   = ((full >> w) & 64'd1) != 0;
        bp   = b;
        ovf  = (((a & msb) != 0) == ((bp & msb) != 0)) && (((res & msb) != 0) != ((a & msb) != 0));
      end
      OP_SUB: begin
        res = (a - b) & mask;
        cy  = (a >= b);
        bp  = (~b + 64'd1) & mask;
        ovf = (((a & msb) != 0) == ((bp & msb) != 0)) && (((res & msb) != 0) != ((a & msb) != 0));
      end
      default: begin
        if (b == 0) begin res = a; dz = 1'b1; end
        else res = a % b;
      end
    endcase
    fl = {dz, ovf, cy, (res == 0)};
  endfunction

  task automatic drive(input int w, input logic vld, input op_t op,
                       input logic [63:0] a, input logic [63:0] b);
    if (w == 8) begin
      bus8.in_valid = vld; bus8.alu_op = op; bus8.a = a[7:0]; bus8.b = b[7:0];
    end else begin
      bus32.in_valid = vld; bus32.alu_op = op; bus32.a = a[31:0]; bus32.b = b[31:0];
    end
  endtask

  task automatic sample(input int w, output logic [63:0] res, output logic [3:0] fl,
                        output logic ov, output logic rdy);
    if (w == 8) begin
      res = {56'd0, bus8.result};
      fl  = {bus8.flag_dz, bus8.flag_ovf, bus8.flag_carry, bus8.flag_zero};
      ov  = bus8.out_valid; rdy = bus8.in_ready;
    end else begin
      res = {32'd0, bus32.result};
      fl  = {bus32.flag_dz, bus32.flag_ovf, bus32.flag_carry, bus32.flag_zero};
      ov  = bus32.out_valid; rdy = bus32.in_ready;
    end
  endtask

  // Issue one request, wait for the result. lat counts rising edges from the accept edge
  // (inclusive) to the one that raised out_valid; 200 means it never came.
  task automatic apply(input int w, input op_t op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output logic [3:0] fl, output int lat);
    logic ov, rdy;
    int n;
    @(negedge clk);
    drive(w, 1'b1, op, a, b);
    n = 0;
    sample(w, res, fl, ov, rdy);
    while (!rdy && n < 200) begin
      @(negedge clk); n++;
      sample(w, res, fl, ov, rdy);
    end
    @(posedge clk); #1;
    drive(w, 1'b0, op, a, b);
    lat = 1;
    while (lat < 200) begin
      @(negedge clk);
      sample(w, res, fl, ov, rdy);
      if (ov) break;
      lat++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] res, eres, mres;
    logic [3:0]  fl, efl, mfl;
    logic        ov, rdy, seen;
    int          lat, k, low, mod_k, w;
    op_t         op;
    logic [63:0] ra, rb;

    vecs[0]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0100};
    vecs[1]  = '{OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0011};
    vecs[2]  = '{OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000};
    vecs[3]  = '{OP_MOD, 32'd100,      32'd7,        32'd2,        4'b0000};
    vecs[4]  = '{OP_MOD, 32'h00001234, 32'h00000000, 32'h00001234, 4'b1000};
    vecs[5]  = '{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0000};
    vecs[6]  = '{OP_OR,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000};
    vecs[7]  = '{OP_XOR, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 4'b0000};
    vecs[8]  = '{OP_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0000};
    vecs[9]  = '{OP_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 4'b0000};
    vecs[10] = '{OP_SLT, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 4'b0001};
    vecs[11] = '{OP_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0000};
    vecs[12] = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0011};
    vecs[13] = '{OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0110};
    vecs[14] = '{OP_MOD, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 4'b0000};
    vecs[15] = '{OP_MOD, 32'd5,        32'd9,        32'd5,        4'b0000};
    vecs[16] = '{OP_MOD, 32'd0,        32'd0,        32'd0,        4'b1001};
    vecs[17] = '{OP_MOD, 32'd21,       32'd7,        32'd0,        4'b0001};
    vecs[18] = '{OP_AND, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 4'b0001};

    rst = 1'b1;
    drive(32, 1'b0, OP_AND, 64'd0, 64'd0);
    drive(8,  1'b0, OP_AND, 64'd0, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state on both widths.
    @(negedge clk);
    sample(32, res, fl, ov, rdy);
    chk("rst32_ready", rdy, 1); chk("rst32_vld", ov, 0);
    chk("rst32_res", res, 0);   chk("rst32_flags", fl, 0);
    sample(8, res, fl, ov, rdy);
    chk("rst8_ready", rdy, 1);  chk("rst8_vld", ov, 0);
    chk("rst8_res", res, 0);    chk("rst8_flags", fl, 0);

    // Directed table at WIDTH=32.
    for (int i = 0; i < 19; i++) begin
      apply(32, vecs[i].op, {32'd0, vecs[i].a}, {32'd0, vecs[i].b}, res, fl, lat);
      chk($sformatf("vec%0d_res", i), res, {32'd0, vecs[i].res});
      chk($sformatf("vec%0d_flags", i), fl, vecs[i].fl);
      chk($sformatf("vec%0d_lat", i), lat,
          (vecs[i].op == OP_MOD && vecs[i].b != 0) ? 33 : 1);
    end

    // Back-to-back single-cycle ops: SUB then SLT on consecutive edges.
    @(negedge clk);
    drive(32, 1'b1, OP_SUB, 64'd5, 64'd5);
    @(posedge clk); #1;
    drive(32, 1'b1, OP_SLT, 64'hFFFFFFFF, 64'd1);
    @(negedge clk);
    sample(32, res, fl, ov, rdy);
    chk("b2b_sub_vld", ov, 1); chk("b2b_sub_res", res, 0);
    chk("b2b_sub_flags", fl, 4'b0011); chk("b2b_ready1", rdy, 1);
    @(posedge clk); #1;
    drive(32, 1'b0, OP_AND, 64'd0, 64'd0);
    @(negedge clk);
    sample(32, res, fl, ov, rdy);
    chk("b2b_slt_vld", ov, 1); chk("b2b_slt_res", res, 1);
    chk("b2b_slt_flags", fl, 0); chk("b2b_ready2", rdy, 1);
    @(negedge clk);
    sample(32, res, fl, ov, rdy);
    chk("b2b_pulse_end", ov, 0); chk("b2b_res_hold", res, 1);

    // Iterative remainder run with a second request held through it.
    @(negedge clk);
    drive(32, 1'b1, OP_MOD, 64'd100, 64'd7);
    @(posedge clk); #1;
    drive(32, 1'b1, OP_ADD, 64'd3, 64'd4);
    k = 0; low = 0; mod_k = 0; mres = 0; mfl = 4'hF;
    while (k < 100) begin
      @(negedge clk); k++;
      sample(32, res, fl, ov, rdy);
      if (ov) begin mod_k = k; mres = res; mfl = fl; end
      if (rdy) break;
      low++;
    end
    chk("mod_ready_low_cycles", low, 32);
    chk("mod_vld_cycle", mod_k, 33);
    chk("mod_res", mres, 2);
    chk("mod_flags", mfl, 0);
    @(posedge clk); #1;
    drive(32, 1'b0, OP_AND, 64'd0, 64'd0);
    @(negedge clk);
    sample(32, res, fl, ov, rdy);
    chk("held_add_vld", ov, 1); chk("held_add_res", res, 7);

    // Make outputs non-zero, then abort a MOD with reset on cycle 10 of the run.
    apply(32, OP_MOD, 64'h1234, 64'd0, res, fl, lat);
    chk("dz_res", res, 64'h1234); chk("dz_flags", fl, 4'b1000); chk("dz_lat", lat, 1);
    @(negedge clk);
    drive(32, 1'b1, OP_MOD, 64'hFFFFFFFF, 64'd3);
    @(posedge clk); #1;
    drive(32, 1'b0, OP_AND, 64'd0, 64'd0);
    repeat (10) @(negedge clk);
    sample(32, res, fl, ov, rdy);
    chk("abort_busy", rdy, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    sample(32, res, fl, ov, rdy);
    chk("abort_vld", ov, 0); chk("abort_res", res, 0);
    chk("abort_flags", fl, 0); chk("abort_ready", rdy, 1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      sample(32, res, fl, ov, rdy);
      if (ov) seen = 1'b1;
    end
    chk("abort_no_late_vld", seen, 0);
    apply(32, OP_AND, 64'hF0F0F0F0, 64'hFF00FF00, res, fl, lat);
    chk("post_abort_and", res, 64'hF000F000); chk("post_abort_lat", lat, 1);

    // WIDTH=8 corner cases.
    apply(8, OP_ADD, 64'hFF, 64'h01, res, fl, lat);
    chk("w8_add_res", res, 0); chk("w8_add_flags", fl, 4'b0011); chk("w8_add_lat", lat, 1);
    apply(8, OP_MOD, 64'd200, 64'd13, res, fl, lat);
    chk("w8_mod_res", res, 5); chk("w8_mod_flags", fl, 0); chk("w8_mod_lat", lat, 9);
    apply(8, OP_SUB, 64'h80, 64'h01, res, fl, lat);
    chk("w8_sub_res", res, 64'h7F); chk("w8_sub_flags", fl, 4'b0110);

    // Random requests against the reference model.
    for (int i = 0; i < 300; i++) begin
      w  = ($urandom_range(0, 3) == 0) ? 8 : 32;
      op = op_t'($urandom_range(0, 7));
      ra = {32'd0, $urandom};
      rb = {32'd0, $urandom};
      if (op == OP_MOD && $urandom_range(0, 1) == 0) rb = rb & 64'hFF;
      if ($urandom_range(0, 7) == 0) rb = 64'd0;
      if (w == 8) begin ra = ra & 64'hFF; rb = rb & 64'hFF; end
      model(w, op, ra, rb, eres, efl);
      apply(w, op, ra, rb, res, fl, lat);
      chk($sformatf("rnd%0d_w%0d_op%0d_res", i, w, op), res, eres);
      chk($sformatf("rnd%0d_w%0d_op%0d_flags", i, w, op), fl, efl);
      chk($sformatf("rnd%0d_w%0d_op%0d_lat", i, w, op), lat,
          (op == OP_MOD && rb != 0) ? w + 1 : 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
